// File: rtl/tpu_result_reader_if.sv
// C-SRAM read port plus the de-skewed result stream of tpu_result_reader.
// out_* handshake: a beat transfers on a clk edge where out_valid & out_ready; once
// out_valid is high, out_data/out_row/out_col/out_last stay stable until that transfer.
interface tpu_result_reader_if #(
   parameter int N   = 16,
   parameter int FPW = 32
);
   logic               sram_re;
   logic [5:0]         sram_raddr;
   logic [N*FPW-1:0]   sram_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [FPW-1:0]     out_data;
   logic [3:0]         out_row;
   logic [3:0]         out_col;
   logic               out_last;

   modport master (
      output sram_re, sram_raddr, out_valid, out_data, out_row, out_col, out_last,
      input  sram_rdata, out_ready
   );

   modport slave (
      input  sram_re, sram_raddr, out_valid, out_data, out_row, out_col, out_last,
      output sram_rdata, out_ready
   );
endinterface

// File: rtl/tpu_result_reader.sv
// Reads diagonal-packed result stripes from C-SRAM and streams C[i][j] in row-major
// order; reads are only issued when the output FIFO is guaranteed room on return.
module tpu_result_reader #(
   parameter int N          = 16,
   parameter int FPW        = 32,
   parameter int BASE_ADDR  = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 srstn,
   input  logic                 rd_start,
   input  logic                 tpu_done,
   tpu_result_reader_if.master  bus,
   output logic                 rd_busy,
   output logic                 rd_done,
   output logic [1:0]           dbg_state
);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = OW + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = FPW + 9;

   if (BASE_ADDR + 2 * N - 2 > 63) begin : g_addr_chk
      $error("tpu_result_reader: stripe addresses do not fit in 6 bits");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t          state;
   logic [3:0]      i_idx, j_idx;
   logic            rd_v, rd_last;
   logic [3:0]      rd_i, rd_j;
   logic [FPW-1:0]  lane;
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [OW-1:0]   occ;
   logic [LW-1:0]   level;
   logic            push, pop, issue, last_ij, slot_free;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign dbg_state = state;
   assign last_ij   = (i_idx == 4'(N - 1)) && (j_idx == 4'(N - 1));
   assign push      = rd_v;
   assign pop       = bus.out_valid & bus.out_ready;
   // Reads still in flight count against FIFO space so a stalled consumer never overflows it.
   assign level     = {1'b0, occ} + LW'(rd_v);
   assign slot_free = (level < LW'(FIFO_DEPTH)) || ((level == LW'(FIFO_DEPTH)) && pop);
   assign issue     = (state == ISSUE) && slot_free;

   assign bus.sram_re    = issue;
   assign bus.sram_raddr = issue ? (6'(BASE_ADDR) + {2'b00, i_idx} + {2'b00, j_idx}) : 6'd0;

   assign bus.out_valid = (occ != '0);
   assign {bus.out_last, bus.out_row, bus.out_col, bus.out_data} = mem[rd_ptr];

   always_comb begin
      lane = '0;
      for (int k = 0; k < N; k++) begin
         if (rd_i == 4'(k)) lane = bus.sram_rdata[k*FPW +: FPW];
      end
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state   <= IDLE;
         i_idx   <= '0;
         j_idx   <= '0;
         rd_busy <= 1'b0;
         rd_done <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_start && tpu_done) begin
                  state   <= ISSUE;
                  rd_busy <= 1'b1;
                  i_idx   <= '0;
                  j_idx   <= '0;
               end
            end
            ISSUE: begin
               if (issue) begin
                  if (last_ij) begin
                     state <= DRAIN;
                  end else if (j_idx == 4'(N - 1)) begin
                     j_idx <= '0;
                     i_idx <= i_idx + 4'd1;
                  end else begin
                     j_idx <= j_idx + 4'd1;
                  end
               end
            end
            DRAIN: begin
               // Finish on the edge that accepts the final beat so rd_done follows it directly.
               if (!rd_v && ((occ == '0) || ((occ == OW'(1)) && pop))) begin
                  state   <= IDLE;
                  rd_busy <= 1'b0;
                  rd_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Lane-select pipeline: tags travel alongside the SRAM's one-cycle read latency.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         rd_v    <= 1'b0;
         rd_i    <= '0;
         rd_j    <= '0;
         rd_last <= 1'b0;
      end else begin
         rd_v    <= issue;
         rd_i    <= i_idx;
         rd_j    <= j_idx;
         rd_last <= last_ij;
      end
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {rd_last, rd_i, rd_j, lane};
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      occ <= occ + OW'(1);
         else if (!push && pop) occ <= occ - OW'(1);
      end
   end
endmodule

// File: tb/tb_tpu_result_reader.sv
// Directed/randomised bench for tpu_result_reader: SRAM model in diagonal layout,
// row-major golden stream and address list, backpressure and reset scenarios.
module tb_tpu_result_reader;
   localparam int N     = 16;
   localparam int FPW   = 32;
   localparam int BASE  = 1;
   localparam int DEPTH = 2;
   localparam int W     = FPW + 9;

   logic clk, srstn, rd_start, tpu_done, rd_busy, rd_done;
   logic [1:0] dbg_state;

   tpu_result_reader_if #(.N(N), .FPW(FPW)) bus ();

   tpu_result_reader #(.N(N), .FPW(FPW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .srstn(srstn), .rd_start(rd_start), .tpu_done(tpu_done),
      .bus(bus), .rd_busy(rd_busy), .rd_done(rd_done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- state ----------------
   int errors = 0;
   int checks = 0;
   logic [FPW-1:0]   mat [N][N];
   logic [N*FPW-1:0] sram [64];
   logic [W-1:0]     exp_q[$];
   logic [5:0]       exp_addr_q[$];
   logic [5:0]       obs_addr [N*N];
   int issued, acc_cnt, done_cnt;
   bit mon_en;
   bit hold_pend;
   logic [W-1:0] held_beat;
   int ready_mode;
   int stall_left;
   bit stall_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] beat_now();
      return {bus.out_last, bus.out_row, bus.out_col, bus.out_data};
   endfunction

   // ---------------- SRAM model (1-cycle read latency) ----------------
   always @(posedge clk) begin
      if (bus.sram_re) bus.sram_rdata <= sram[bus.sram_raddr];
   end

   // ---------------- ready driver ----------------
   initial begin
      bus.out_ready = 1'b1;
      stall_left = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            1: bus.out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (acc_cnt == 40 && !stall_done) begin
                  stall_left = 10;
                  stall_done = 1'b1;
               end
               if (stall_left > 0) begin
                  bus.out_ready = 1'b0;
                  stall_left--;
               end else begin
                  bus.out_ready = 1'b1;
               end
            end
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // ---------------- reference model ----------------
   task automatic load_matrix(input int mode);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            mat[i][j] = (mode == 0) ? (32'h4000_0000 | 32'((i << 4) | j)) : $urandom;
      for (int a = 0; a < 64; a++)
         for (int k = 0; k < N; k++) sram[a][k*FPW +: FPW] = $urandom;
      for (int d = 0; d <= 2*N-2; d++)
         for (int k = 0; k < N; k++)
            if (d - k >= 0 && d - k < N) sram[BASE + d][k*FPW +: FPW] = mat[k][d-k];
   endtask

   task automatic push_expected();
      issued = 0;
      acc_cnt = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            exp_q.push_back({1'(i == N-1 && j == N-1), 4'(i), 4'(j), mat[i][j]});
            exp_addr_q.push_back(6'(BASE + i + j));
         end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (hold_pend) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_beat", 64'(beat_now()), 64'(held_beat));
         end
         hold_pend = bus.out_valid && !bus.out_ready;
         held_beat = beat_now();
         if (bus.sram_re) begin
            chk("read_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) chk("read_addr", 64'(bus.sram_raddr), 64'(exp_addr_q.pop_front()));
            if (issued < N*N) obs_addr[issued] = bus.sram_raddr;
            issued++;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("beat", 64'(beat_now()), 64'(exp_q.pop_front()));
            acc_cnt++;
         end
         if (bus.sram_re || (bus.out_valid && bus.out_ready))
            chk("outstanding_le_depth", 64'(issued - acc_cnt <= DEPTH), 64'd1);
         if (rd_done) begin
            done_cnt++;
            chk("done_after_all_beats", 64'(exp_q.size()), 64'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_read();
      @(negedge clk);
      rd_start = 1'b1;
      tpu_done = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_done_in_time"}, 64'(done_cnt != d0), 64'd1);
      chk({tag, "_all_beats"}, 64'(acc_cnt), 64'(N*N));
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sram_re"}, 64'(bus.sram_re), 64'd0);
      chk({tag, "_sram_raddr"}, 64'(bus.sram_raddr), 64'd0);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
      chk({tag, "_out_row_col"}, 64'({bus.out_row, bus.out_col}), 64'd0);
      chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
      chk({tag, "_rd_busy"}, 64'(rd_busy), 64'd0);
      chk({tag, "_rd_done"}, 64'(rd_done), 64'd0);
      chk({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
   endtask

   // ---------------- global watchdog ----------------
   initial begin
      #500000;
      $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int d0;
      srstn = 1'b0;
      rd_start = 1'b0;
      tpu_done = 1'b0;
      ready_mode = 0;
      mon_en = 1'b0;
      hold_pend = 1'b0;
      stall_done = 1'b0;
      done_cnt = 0;
      issued = 0;
      acc_cnt = 0;
      @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      srstn = 1'b1;
      mon_en = 1'b1;

      // 1: pattern matrix, ready high, latency and back-to-back beats
      load_matrix(0);
      push_expected();
      @(negedge clk);
      rd_start = 1'b1;
      tpu_done = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      chk("first_read_latency", 64'(bus.sram_re), 64'd1);
      chk("busy_after_start", 64'(rd_busy), 64'd1);
      @(negedge clk);
      chk("no_valid_before_2cyc", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("first_valid_latency", 64'(bus.out_valid), 64'd1);
      chk("first_beat_rc", 64'({bus.out_row, bus.out_col}), 64'd0);
      n = 0;
      while (bus.out_valid && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("consecutive_beats", 64'(n), 64'(N*N));
      chk("done_after_last", 64'(rd_done), 64'd1);
      @(negedge clk);
      #1;
      chk("done_one_cycle", 64'(rd_done), 64'd0);
      chk("busy_cleared", 64'(rd_busy), 64'd0);
      chk("t1_done_count", 64'(done_cnt), 64'd1);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      // 2: address spot checks
      chk("addr_beat_3_5", 64'(obs_addr[3*N+5]), 64'(BASE + 8));
      chk("addr_beat_15_15", 64'(obs_addr[N*N-1]), 64'd31);

      // 3: 10-cycle stall at beat 40
      load_matrix(1);
      push_expected();
      stall_done = 1'b0;
      ready_mode = 2;
      start_read();
      wait_done("stall", 2000);
      chk("stall_applied", 64'(stall_done), 64'd1);

      // 4: random 50% ready
      load_matrix(1);
      push_expected();
      ready_mode = 1;
      start_read();
      wait_done("random_ready", 3000);

      // 5: ignored starts
      ready_mode = 0;
      @(negedge clk);
      issued = 0;
      tpu_done = 1'b0;
      rd_start = 1'b1;
      repeat (5) @(negedge clk);
      rd_start = 1'b0;
      #1;
      chk("no_start_without_tpu_done", 64'(rd_busy), 64'd0);
      chk("no_reads_without_tpu_done", 64'(issued), 64'd0);
      load_matrix(1);
      push_expected();
      d0 = done_cnt;
      start_read();
      repeat (30) @(negedge clk);
      rd_start = 1'b1;
      repeat (2) @(negedge clk);
      rd_start = 1'b0;
      wait_done("busy_restart", 2000);
      repeat (10) @(negedge clk);
      #1;
      chk("single_stream_done", 64'(done_cnt - d0), 64'd1);
      chk("single_stream_reads", 64'(issued), 64'(N*N));
      chk("idle_after_stream", 64'(rd_busy), 64'd0);

      // 6: reset at beat 100, then full restart
      load_matrix(1);
      push_expected();
      ready_mode = 1;
      start_read();
      n = 0;
      while (acc_cnt < 100 && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("reached_beat_100", 64'(acc_cnt >= 100), 64'd1);
      mon_en = 1'b0;
      srstn = 1'b0;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      check_zero("reset_next_cycle");
      repeat (2) @(negedge clk);
      chk("no_done_in_reset", 64'(rd_done), 64'd0);
      exp_q.delete();
      exp_addr_q.delete();
      hold_pend = 1'b0;
      srstn = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 64'(rd_busy), 64'd0);
      mon_en = 1'b1;
      load_matrix(1);
      push_expected();
      ready_mode = 0;
      d0 = done_cnt;
      start_read();
      wait_done("post_reset", 2000);
      chk("post_reset_done_once", 64'(done_cnt - d0), 64'd1);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
